// File: rtl/cheri_dmem_sram_bridge.sv
// CHERI data-memory to single-port tagged SRAM bridge.
// Revocation-map reads take priority; data responses arrive one cycle after grant.
module cheri_dmem_sram_bridge #(
  parameter logic [31:0] MemBase  = 32'h200F_0000,
  parameter int unsigned MemWords = 16384
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic        data_is_cap_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        tsmap_cs_i,
  input  logic [13:0] tsmap_addr_i,
  output logic [32:0] tsmap_rdata_o,
  output logic        sram_cs_o,
  output logic        sram_we_o,
  output logic [13:0] sram_addr_o,
  output logic [3:0]  sram_be_o,
  output logic [32:0] sram_wdata_o,
  input  logic [32:0] sram_rdata_i,
  output logic [15:0] conflict_cnt_o
);

  localparam logic [32:0] LP_LO = {1'b0, MemBase};
  localparam logic [32:0] LP_HI = {1'b0, MemBase} + 33'(4 * MemWords);

  logic        w_gnt;
  logic        w_in_range;
  logic        w_cap_bad;
  logic        w_err;
  logic        w_acc;
  logic        r_rvalid;
  logic        r_err;
  logic        r_rd;
  logic        r_cap;
  logic        r_ts;
  logic [15:0] r_cnt;

  assign w_gnt      = data_req_i & ~tsmap_cs_i;
  assign w_in_range = ({1'b0, data_addr_i} >= LP_LO)
                    & ({1'b0, data_addr_i} <  LP_HI);
  assign w_cap_bad  = data_is_cap_i
                    & ((data_addr_i[1:0] != 2'b00) | (data_be_i != 4'hF));
  assign w_err      = ~w_in_range | w_cap_bad;
  assign w_acc      = w_gnt & ~w_err;

  assign data_gnt_o = w_gnt;

  // Steer the SRAM port: revocation map first, then a legal data access.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    unique case (1'b1)
      tsmap_cs_i: begin
        sram_cs_o   = 1'b1;
        sram_addr_o = tsmap_addr_i;
      end
      w_acc: begin
        sram_cs_o   = 1'b1;
        sram_we_o   = data_we_i;
        sram_addr_o = 14'((data_addr_i - MemBase) >> 2);
        sram_be_o   = data_be_i;
        if (data_we_i) begin
          sram_wdata_o = {data_is_cap_i & data_wdata_i[32],
                          data_wdata_i[31:0]};
        end
      end
      default: ;
    endcase
  end

  // One-stage response pipeline and saturating conflict counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
      r_cap    <= 1'b0;
      r_ts     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & w_err;
      r_rd     <= w_acc & ~data_we_i;
      r_cap    <= data_is_cap_i;
      r_ts     <= tsmap_cs_i;
      if (data_req_i & tsmap_cs_i & (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign data_rvalid_o  = r_rvalid;
  assign data_err_o     = r_err;
  assign data_rdata_o   = r_rd ? {r_cap & sram_rdata_i[32],
                                  sram_rdata_i[31:0]} : '0;
  assign tsmap_rdata_o  = r_ts ? sram_rdata_i : '0;
  assign conflict_cnt_o = r_cnt;

endmodule
